video_timing: RTL and testbench

Horizontal/vertical raster timing generator for the video path, directly downstream of the clock divider. It runs on the 24 MHz master clock and uses the 6 MHz pixel clock (CLK_6MB) as a sampled level rather than as a clock. From it, the block derives a one-cycle pixel enable, pixel and line counters, sync and blanking, and the per-line and per-frame strobes consumed by sprite/fix rendering and the interrupt logic.

---
 rtl/video_timing.sv | 109 ++++++++++
 tb/tb_video_timing.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// Raster timing generator: samples the 6 MHz pixel clock level on CLK_24M,
// derives the pixel enable, H/V counters, sync/blank decode and line/frame strobes.
module video_timing #(
  parameter int unsigned H_ACTIVE       = 320,
  parameter int unsigned H_SYNC_START   = 336,
  parameter int unsigned H_SYNC_LEN     = 29,
  parameter int unsigned H_TOTAL        = 384,
  parameter int unsigned V_ACTIVE_START = 16,
  parameter int unsigned V_ACTIVE_END   = 240,
  parameter int unsigned V_SYNC_START   = 248,
  parameter int unsigned V_SYNC_LEN     = 8,
  parameter int unsigned V_TOTAL        = 264
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       CLK_6MB,
  output logic       PIX_EN,
  output logic [8:0] H_COUNT,
  output logic [8:0] V_COUNT,
  output logic       nHSYNC,
  output logic       nVSYNC,
  output logic       nBNK,
  output logic       LINE_STB,
  output logic       FRAME_STB,
  output logic       VBL_IRQ
);

  localparam int unsigned CW = 9;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_SYNC_START);
  localparam logic [CW-1:0] HS_END   = CW'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [CW-1:0] VA_BEG   = CW'(V_ACTIVE_START);
  localparam logic [CW-1:0] VA_END   = CW'(V_ACTIVE_END);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_SYNC_START);
  localparam logic [CW-1:0] VS_END   = CW'(V_SYNC_START + V_SYNC_LEN);

  logic          c6_d;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          line_adv;
  logic          hsync_n_nxt;
  logic          vsync_n_nxt;
  logic          bnk_n_nxt;
  logic          frame_nxt;
  logic          vbl_nxt;

  // Rising-edge detect of the pixel clock level; gated so reset never advances.
  assign PIX_EN = CLK_6MB & ~c6_d & ~RESET;

  // Next counter values; hold on cycles without a pixel advance.
  always_comb begin
    h_nxt    = H_COUNT;
    v_nxt    = V_COUNT;
    line_adv = 1'b0;
    if (PIX_EN) begin
      if (H_COUNT == H_LAST) begin
        h_nxt    = '0;
        line_adv = 1'b1;
      end else begin
        h_nxt = H_COUNT + CW'(1);
      end
    end
    if (line_adv) begin
      if (V_COUNT == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = V_COUNT + CW'(1);
      end
    end
  end

  // Decode from next values so registered sync/blank line up with the counters.
  always_comb begin
    hsync_n_nxt = ~((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vsync_n_nxt = ~((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    bnk_n_nxt   = (h_nxt < H_ACT) && (v_nxt >= VA_BEG) && (v_nxt < VA_END);
    frame_nxt   = line_adv && (v_nxt == '0);
    vbl_nxt     = line_adv && (v_nxt == VA_END);
  end

  // c6_d resets high to match the divider, so release needs a fresh rising edge.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      c6_d      <= 1'b1;
      H_COUNT   <= '0;
      V_COUNT   <= '0;
      nHSYNC    <= 1'b1;
      nVSYNC    <= 1'b1;
      nBNK      <= 1'b0;
      LINE_STB  <= 1'b0;
      FRAME_STB <= 1'b0;
      VBL_IRQ   <= 1'b0;
    end else begin
      c6_d      <= CLK_6MB;
      H_COUNT   <= h_nxt;
      V_COUNT   <= v_nxt;
      nHSYNC    <= hsync_n_nxt;
      nVSYNC    <= vsync_n_nxt;
      nBNK      <= bnk_n_nxt;
      LINE_STB  <= line_adv;
      FRAME_STB <= frame_nxt;
      VBL_IRQ   <= vbl_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: pixel-count model plus directed checks.
// The vertical geometry is shrunk so full frames fit in a short run.
module tb_video_timing;

  localparam int HA  = 320;
  localparam int HSS = 336;
  localparam int HSL = 29;
  localparam int HT  = 384;
  localparam int VAS = 2;
  localparam int VAE = 6;
  localparam int VSS = 7;
  localparam int VSL = 2;
  localparam int VT  = 10;

  logic       CLK_24M = 1'b0;
  logic       RESET   = 1'b1;
  logic       CLK_6MB = 1'b1;
  logic       PIX_EN;
  logic [8:0] H_COUNT;
  logic [8:0] V_COUNT;
  logic       nHSYNC, nVSYNC, nBNK, LINE_STB, FRAME_STB, VBL_IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  video_timing #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_ACTIVE_START(VAS), .V_ACTIVE_END(VAE), .V_SYNC_START(VSS),
    .V_SYNC_LEN(VSL), .V_TOTAL(VT)
  ) dut (
    .CLK_24M(CLK_24M), .RESET(RESET), .CLK_6MB(CLK_6MB), .PIX_EN(PIX_EN),
    .H_COUNT(H_COUNT), .V_COUNT(V_COUNT), .nHSYNC(nHSYNC), .nVSYNC(nVSYNC),
    .nBNK(nBNK), .LINE_STB(LINE_STB), .FRAME_STB(FRAME_STB), .VBL_IRQ(VBL_IRQ)
  );

  initial forever #5 CLK_24M = ~CLK_24M;

  // Reference divide-by-4 pixel clock, changing on the falling edge; run=0 freezes it.
  int ph  = 0;
  bit run = 1'b1;
  initial forever begin
    @(negedge CLK_24M);
    if (run) begin
      ph      = (ph + 1) % 4;
      CLK_6MB = (ph < 2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Model: n = pixel advances since reset; everything else is arithmetic on n.
  int n = 0;
  bit prev6 = 1'b1;
  bit e_line = 1'b0, e_frame = 1'b0, e_vbl = 1'b0;
  bit pe;
  initial forever begin
    @(posedge CLK_24M);
    if (RESET) begin
      n = 0; prev6 = 1'b1; e_line = 1'b0; e_frame = 1'b0; e_vbl = 1'b0;
    end else begin
      pe      = CLK_6MB && !prev6;
      prev6   = CLK_6MB;
      e_line  = 1'b0; e_frame = 1'b0; e_vbl = 1'b0;
      if (pe) begin
        n++;
        e_line  = (n % HT == 0);
        e_frame = e_line && ((n / HT) % VT == 0);
        e_vbl   = e_line && ((n / HT) % VT == VAE);
      end
    end
  end

  // Every-cycle compare, sampled just after the falling edge.
  int eh, ev;
  bit ehs, evs, ebn, el, ef, eq, ep;
  initial forever begin
    @(negedge CLK_24M);
    #1;
    if (RESET) begin
      eh = 0; ev = 0; ehs = 1; evs = 1; ebn = 0; el = 0; ef = 0; eq = 0; ep = 0;
    end else begin
      eh  = n % HT;
      ev  = (n / HT) % VT;
      ehs = !(eh >= HSS && eh < HSS + HSL);
      evs = !(ev >= VSS && ev < VSS + VSL);
      ebn = (eh < HA) && (ev >= VAS) && (ev < VAE);
      el = e_line; ef = e_frame; eq = e_vbl;
      ep  = CLK_6MB && !prev6;
    end
    chk("m_h", H_COUNT, eh);
    chk("m_v", V_COUNT, ev);
    chk("m_hsync", nHSYNC, ehs);
    chk("m_vsync", nVSYNC, evs);
    chk("m_bnk", nBNK, ebn);
    chk("m_line", LINE_STB, el);
    chk("m_frame", FRAME_STB, ef);
    chk("m_vbl", VBL_IRQ, eq);
    chk("m_pix", PIX_EN, ep);
  end

  task automatic step();
    @(negedge CLK_24M);
    #1;
  endtask

  task automatic wait_hv(input int h, input int v, input int lim, input string nm);
    int k = 0;
    while (!(H_COUNT == 9'(h) && V_COUNT == 9'(v)) && k < lim) begin
      step();
      k++;
    end
    if (k >= lim) timeout(nm);
  endtask

  task automatic wait_pix(input int lim, input string nm);
    int k = 0;
    while (PIX_EN !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    if (k >= lim) timeout(nm);
  endtask

  task automatic hold_clk(input bit level, input string nm);
    int pix = 0;
    while (CLK_6MB !== level) step();
    run = 1'b0;
    repeat (50) begin
      step();
      if (PIX_EN) pix++;
    end
    chk({nm, "_pix_cnt"}, pix, 0);
    run = 1'b1;
    wait_pix(8, {nm, "_resume"});
  endtask

  int c_pix, c_hs, c_line, c_frame, c_vbl, c_vs, c_bnk;

  initial begin
    repeat (10) step();
    chk("rst_h", H_COUNT, 0);
    chk("rst_v", V_COUNT, 0);
    chk("rst_hsync", nHSYNC, 1);
    chk("rst_vsync", nVSYNC, 1);
    chk("rst_bnk", nBNK, 0);
    chk("rst_line", LINE_STB, 0);
    chk("rst_pix", PIX_EN, 0);
    @(posedge CLK_24M);
    #2 RESET = 1'b0;

    // First sampled rising edge gives H=1 one cycle later.
    wait_pix(8, "first_pix");
    chk("first_h0", H_COUNT, 0);
    step();
    chk("first_h1", H_COUNT, 1);

    // Cadence: 100 pulses in 400 cycles, still in top blanking.
    c_pix = 0;
    repeat (400) begin
      step();
      if (PIX_EN) c_pix++;
    end
    chk("cad_pix_cnt", c_pix, 100);
    chk("cad_h", H_COUNT, 101);
    chk("cad_v", V_COUNT, 0);
    chk("cad_bnk", nBNK, 0);

    // Line wrap into the first active line.
    wait_hv(HT - 1, VAS - 1, 5000, "wait_line_wrap");
    wait_pix(8, "wrap_pix");
    step();
    chk("wrap_h", H_COUNT, 0);
    chk("wrap_v", V_COUNT, VAS);
    chk("wrap_line", LINE_STB, 1);
    chk("wrap_bnk", nBNK, 1);
    step();
    chk("wrap_line_1cyc", LINE_STB, 0);

    c_hs = 0; c_line = 0;
    repeat (HT * 4) begin
      step();
      if (!nHSYNC) c_hs++;
      if (LINE_STB) c_line++;
    end
    chk("line_hsync_cycles", c_hs, 116);
    chk("line_stb_cnt", c_line, 1);

    // One full frame window.
    c_line = 0; c_frame = 0; c_vbl = 0; c_vs = 0; c_bnk = 0;
    repeat (HT * 4 * VT) begin
      step();
      if (LINE_STB) c_line++;
      if (VBL_IRQ) begin
        c_vbl++;
        chk("vbl_h", H_COUNT, 0);
        chk("vbl_v", V_COUNT, VAE);
      end
      if (!nVSYNC) c_vs++;
      if (nBNK) c_bnk++;
      if (FRAME_STB) begin
        c_frame++;
        chk("frame_line", LINE_STB, 1);
        chk("frame_h", H_COUNT, 0);
        chk("frame_v", V_COUNT, 0);
      end
    end
    chk("frame_line_cnt", c_line, VT);
    chk("frame_stb_cnt", c_frame, 1);
    chk("frame_vbl_cnt", c_vbl, 1);
    chk("frame_vsync_cycles", c_vs, VSL * HT * 4);
    chk("frame_bnk_cycles", c_bnk, (VAE - VAS) * HA * 4);

    // Asynchronous reset mid-line.
    wait_hv(200, 5, 16000, "wait_mid_reset");
    @(posedge CLK_24M);
    #2 RESET = 1'b1;
    #1;
    chk("arst_h", H_COUNT, 0);
    chk("arst_v", V_COUNT, 0);
    chk("arst_hsync", nHSYNC, 1);
    chk("arst_vsync", nVSYNC, 1);
    chk("arst_bnk", nBNK, 0);
    chk("arst_pix", PIX_EN, 0);
    repeat (3) @(posedge CLK_24M);
    #2 RESET = 1'b0;
    c_line = 0; c_frame = 0; c_vbl = 0;
    repeat (1000) begin
      step();
      if (LINE_STB) c_line++;
      if (FRAME_STB) c_frame++;
      if (VBL_IRQ) c_vbl++;
    end
    chk("arst_no_line", c_line, 0);
    chk("arst_no_frame", c_frame, 0);
    chk("arst_no_vbl", c_vbl, 0);

    // Static pixel clock, high then low.
    wait_hv(300, 0, 2000, "wait_static");
    hold_clk(1'b1, "static_hi");
    hold_clk(1'b0, "static_lo");
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
